// File: rtl/prod_modred_pkg.sv
// Shared types and sizing for the prod_modred modular-reduction stage.
package prod_modred_pkg;

  localparam int unsigned DEF_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width: enough to count 2W product bits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (2 * w <= 2) ? 1 : $clog2(2 * w);
  endfunction

endpackage

// File: rtl/prod_modred_step.sv
// One restoring shift-subtract step: next R = ({R, bit}) mod M, given R < M.
module prod_modred_step
  import prod_modred_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic [W-1:0] r_i,
  input  logic         bit_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] r_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // shifted[W] is the transient compare bit; the result always fits in W bits.
  always_comb begin
    shifted = {r_i, bit_i};
    diff    = shifted - {1'b0, m_i};
    r_o     = (shifted >= {1'b0, m_i}) ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/prod_modred.sv
// Bit-serial P mod M reducer behind the Booth multiplier.
// PROD_MODRED_FASTPATH_EN: bypass the shift loop when P < M.
module prod_modred
  import prod_modred_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_p,
  input  logic [W-1:0]   in_m,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_r,
  output logic           out_err
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(PW - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic [W-1:0]    m_q, m_d;
  logic [W-1:0]    r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_r_q, out_r_d;
  logic            out_err_q, out_err_d;
  logic [W-1:0]    r_step;

  prod_modred_step #(.W(W)) u_step (
    .r_i   (r_q),
    .bit_i (p_q[PW-1]),
    .m_i   (m_q),
    .r_o   (r_step)
  );

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    m_d         = m_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_err_d   = out_err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          p_d   = in_p;
          m_d   = in_m;
          r_d   = '0;
          cnt_d = '0;
          err_d = 1'b0;
          if (in_m == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
`ifdef PROD_MODRED_FASTPATH_EN
          end else if (in_p < {{W{1'b0}}, in_m}) begin
            r_d     = in_p[W-1:0];
            state_d = DONE;
`endif
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = r_step;
        p_d   = {p_q[PW-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_r_d     = r_step;
          out_err_d   = err_q;
        end
      end
      DONE: begin
        // Direct entries (error / bypass) publish one edge after accept.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_r_d     = r_q;
          out_err_d   = err_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      m_q         <= m_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_err   = out_err_q;

endmodule

// File: doc/prod_modred.md
# prod_modred

Sequential modular-reduction stage that sits directly downstream of the 20x20 Booth multiplier. It accepts the 2W-bit product P and a W-bit modulus M over a valid/ready handshake, and computes R = P mod M with a bit-serial restoring shift-subtract loop, one product bit per cycle. It returns R over a second valid/ready handshake. It closes the modular-multiply path used by the crypto datapaths: multiplier, then prod_modred, then consumer.

## Interface
- W, default 20: operand/modulus width; the product width is 2W.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  P/M offered.
- in_ready  out  1  block can accept; equals (state == IDLE).
- in_p  in  2W  product from the multiplier.
- in_m  in  W  modulus.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_r  out  W  remainder, P mod M.
- out_err  out  1  M was zero.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE.** On in_valid && in_ready:
  - latch in_p into the shift register and in_m into the modulus register;
  - clear the remainder register R (W+1 bits) and the bit counter (clog2(2W) bits).
  - Next state: DONE with err=1 and R=0 if in_m==0; otherwise RUN.
- **RUN.** Each cycle:
  - R' = {R[W-1:0], p_msb}; shift P left by one;
  - if R' >= M then R = R' - M, else R = R'.
  - The counter increments; after the 2W-th step, go to DONE.
- **DONE.** out_valid=1; out_r=R[W-1:0]; out_err is the latched flag. On out_valid && out_ready, go to IDLE.
- Invariant: R < M after every step, so R[W] is only a transient compare bit.
- in_valid is ignored outside IDLE. The input side applies no backpressure except through in_ready.
- Inputs are sampled only on the accept edge; in_p and in_m may change afterwards.
- **Reset,** asynchronous, at any time including mid-RUN:
  - state=IDLE; R, P, M registers and counter cleared;
  - out_valid=0, out_r=0, out_err=0, in_ready=1.
  - No partial result is ever presented.

## Timing
- Accept edge T0, normal path: out_valid is high after edge T0+2W (40 cycles for W=20).
- M==0 path: out_valid is high after edge T0+1.
- out_r and out_err are held stable while out_valid=1 && out_ready=0.
- On the output handshake edge, out_valid drops and in_ready rises in the following cycle. The earliest next accept is one edge after the output handshake.
- Minimum spacing between accepts is 2W+2 cycles. There is no overlap between consecutive transactions.
- All outputs are registered, or decoded from registered state, with no combinational in-to-out path.

## Configuration
- PROD_MODRED_FASTPATH_EN defined:
  - At accept, if in_p < {W'b0, in_m}, skip RUN and go straight to DONE with R=in_p[W-1:0].
  - out_valid is high after edge T0+1.
  - M==0 still takes the error path; the error check has priority.
- Not defined: every non-zero-M transaction takes the full 2W RUN cycles. Results are identical in both cases; only latency differs.

## Structure
- Package prod_modred_pkg holds:
  - the state enum typedef (IDLE/RUN/DONE);
  - default-width localparams;
  - a width function for the counter.
- Sub-module prod_modred_step: a purely combinational single restoring step, (R, bit, M) to next R.
  - Instantiated once.
  - Keeps the compare/subtract isolated so it can be replaced by a multi-bit radix step later.

## Test plan
- P=100, M=7, out_ready=1: out_r=2, out_err=0, out_valid exactly 40 cycles after accept.
- P=5, M=7: out_r=5. Latency is 40 without the macro and 1 with PROD_MODRED_FASTPATH_EN.
- P=0xFFFFFFFFFF, M=0xFFFFF: out_r=0, since 2^40-1 = (2^20-1)(2^20+1).
- M=0, P=0x123: out_err=1, out_r=0, out_valid after 1 cycle. The next transaction (P=10, M=3) returns 1 with err=0.
- Hold out_ready=0 for 10 cycles in DONE while in_valid toggles with new data:
  - out_r and out_err stay stable and in_ready stays 0;
  - the new data is not consumed until after the output handshake.
- Assert rst_n=0 at RUN step 20:
  - out_valid=0 and in_ready=1 immediately, all outputs zero;
  - after release, P=1000, M=13 returns 12 with normal latency.
